sm4_ck_seq: RTL and testbench



---
 rtl/sm4_pkg.sv | 40 ++++
 rtl/sm4_ck_lane.sv | 23 ++
 rtl/sm4_ck_seq.sv | 117 +++++++++++
 tb/tb_sm4_ck_seq.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sm4_pkg.sv
// Shared SM4 key-expansion types, CK constant table and arithmetic CK generator.
package sm4_pkg;

  localparam int unsigned SM4_ROUNDS  = 32;
  localparam int unsigned SM4_CK_STEP = 7;
  localparam int unsigned SM4_IDX_W   = 5;
  localparam int unsigned SM4_WORD_W  = 32;

  typedef logic [SM4_WORD_W-1:0] ck_word_t;
  typedef logic [SM4_IDX_W-1:0]  round_idx_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } ck_seq_state_t;

  // CK[i] byte j = (28*i + 7*j) mod 256, byte 0 in the MSB.
  localparam ck_word_t SM4_CK_TAB [SM4_ROUNDS] = '{
    32'h00070e15, 32'h1c232a31, 32'h383f464d, 32'h545b6269,
    32'h70777e85, 32'h8c939aa1, 32'ha8afb6bd, 32'hc4cbd2d9,
    32'he0e7eef5, 32'hfc030a11, 32'h181f262d, 32'h343b4249,
    32'h50575e65, 32'h6c737a81, 32'h888f969d, 32'ha4abb2b9,
    32'hc0c7ced5, 32'hdce3eaf1, 32'hf8ff060d, 32'h141b2229,
    32'h30373e45, 32'h4c535a61, 32'h686f767d, 32'h848b9299,
    32'ha0a7aeb5, 32'hbcc3cad1, 32'hd8dfe6ed, 32'hf4fb0209,
    32'h10171e25, 32'h2c333a41, 32'h484f565d, 32'h646b7279
  };

  // Byte j of round i is step*(4i+j) truncated to 8 bits.
  function automatic ck_word_t ck_calc(input round_idx_t idx,
                                       input int unsigned step = SM4_CK_STEP);
    ck_word_t w;
    w = '0;
    for (int unsigned j = 0; j < 4; j++) begin
      w[8*(3-j) +: 8] = 8'(((32'(idx) << 2) + j) * step);
    end
    return w;
  endfunction

endpackage

// File: rtl/sm4_ck_lane.sv
// One CK lane: round index in, CK word out (combinational).
// SM4_CK_ROM_EN selects the constant table instead of the arithmetic generator.
module sm4_ck_lane
  import sm4_pkg::*;
#(
  parameter int unsigned BYTE_STEP = SM4_CK_STEP
) (
  input  round_idx_t i_idx,
  output ck_word_t   o_ck_c
);

`ifdef SM4_CK_ROM_EN
  // The table only holds the standard step; any other step falls back to arithmetic.
  if (BYTE_STEP == SM4_CK_STEP) begin : g_rom
    assign o_ck_c = SM4_CK_TAB[i_idx];
  end else begin : g_calc
    assign o_ck_c = ck_calc(i_idx, BYTE_STEP);
  end
`else
  assign o_ck_c = ck_calc(i_idx, BYTE_STEP);
`endif

endmodule

// File: rtl/sm4_ck_seq.sv
// SM4 CK constant sequencer: streams all round constants, LANES per beat, fwd or reverse.
// Build option SM4_CK_ROM_EN (in sm4_ck_lane) switches the lanes to the constant table.
module sm4_ck_seq
  import sm4_pkg::*;
#(
  parameter int unsigned LANES     = 1,
  parameter int unsigned ROUNDS    = SM4_ROUNDS,
  parameter int unsigned BYTE_STEP = SM4_CK_STEP
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  dir,
  input  logic                  flush,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [32*LANES-1:0]   ck_out,
  output logic [SM4_IDX_W-1:0]  ck_index,
  output logic                  last,
  output logic                  busy
);

  localparam int unsigned OUT_W = 32 * LANES;

  ck_seq_state_t      r_state;
  logic               r_dir;
  logic               r_valid;
  logic [OUT_W-1:0]   r_ck;
  round_idx_t         r_index;
  logic               r_last;

  logic               w_fire;
  logic               w_dir_sel;
  round_idx_t         w_base;
  logic               w_base_last;
  logic [OUT_W-1:0]   w_lanes;

  assign w_fire = r_valid && out_ready;

  // Lane-0 index of the beat that would be loaded next (first beat from IDLE, else stepped).
  always_comb begin
    w_dir_sel   = r_dir;
    w_base      = r_index;
    w_base_last = 1'b0;
    if (r_state == ST_IDLE) begin
      w_dir_sel = dir;
      w_base    = dir ? SM4_IDX_W'(ROUNDS - 1) : '0;
    end else begin
      w_base = r_dir ? (r_index - SM4_IDX_W'(LANES)) : (r_index + SM4_IDX_W'(LANES));
    end
    w_base_last = w_dir_sel ? (w_base == SM4_IDX_W'(LANES - 1))
                            : (w_base == SM4_IDX_W'(ROUNDS - LANES));
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    round_idx_t w_idx;
    assign w_idx = w_dir_sel ? (w_base - SM4_IDX_W'(k)) : (w_base + SM4_IDX_W'(k));
    sm4_ck_lane #(
      .BYTE_STEP (BYTE_STEP)
    ) u_lane (
      .i_idx  (w_idx),
      .o_ck_c (w_lanes[32*k +: 32])
    );
  end

  // Sequencer FSM and output register; flush overrides both transfer and start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_dir   <= 1'b0;
      r_valid <= 1'b0;
      r_ck    <= '0;
      r_index <= '0;
      r_last  <= 1'b0;
    end else if (flush) begin
      if (r_state == ST_RUN) begin
        r_state <= ST_IDLE;
        r_valid <= 1'b0;
        r_last  <= 1'b0;
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_RUN;
            r_dir   <= dir;
            r_valid <= 1'b1;
            r_ck    <= w_lanes;
            r_index <= w_base;
            r_last  <= w_base_last;
          end
        end
        ST_RUN: begin
          if (w_fire) begin
            if (r_last) begin
              r_state <= ST_IDLE;
              r_valid <= 1'b0;
              r_last  <= 1'b0;
            end else begin
              r_ck    <= w_lanes;
              r_index <= w_base;
              r_last  <= w_base_last;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign out_valid = r_valid;
  assign ck_out    = r_ck;
  assign ck_index  = r_index;
  assign last      = r_last;
  assign busy      = (r_state == ST_RUN);

endmodule

// File: tb/tb_sm4_ck_seq.sv
// Scoreboard bench for sm4_ck_seq with LANES = 1, 2 and 4 instances side by side.
module tb_sm4_ck_seq;

  typedef struct packed {
    logic [127:0] ck;
    logic [4:0]   idx;
    logic         last;
  } exp_t;

  logic clk;
  logic rst_n;
  logic [2:0] start_v, dir_v, flush_v, ready_v;
  logic [2:0] valid_v, last_v, busy_v;
  logic [4:0] idx0, idx1, idx2;
  logic [31:0]  ck1;
  logic [63:0]  ck2;
  logic [127:0] ck4;

  logic [31:0] ck_tab [32] = '{
    32'h00070e15, 32'h1c232a31, 32'h383f464d, 32'h545b6269,
    32'h70777e85, 32'h8c939aa1, 32'ha8afb6bd, 32'hc4cbd2d9,
    32'he0e7eef5, 32'hfc030a11, 32'h181f262d, 32'h343b4249,
    32'h50575e65, 32'h6c737a81, 32'h888f969d, 32'ha4abb2b9,
    32'hc0c7ced5, 32'hdce3eaf1, 32'hf8ff060d, 32'h141b2229,
    32'h30373e45, 32'h4c535a61, 32'h686f767d, 32'h848b9299,
    32'ha0a7aeb5, 32'hbcc3cad1, 32'hd8dfe6ed, 32'hf4fb0209,
    32'h10171e25, 32'h2c333a41, 32'h484f565d, 32'h646b7279
  };

  exp_t q0[$], q1[$], q2[$];
  int n_chk  = 0;
  int n_pass = 0;

  sm4_ck_seq #(.LANES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .dir(dir_v[0]), .flush(flush_v[0]),
    .out_ready(ready_v[0]), .out_valid(valid_v[0]), .ck_out(ck1), .ck_index(idx0),
    .last(last_v[0]), .busy(busy_v[0]));
  sm4_ck_seq #(.LANES(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .dir(dir_v[1]), .flush(flush_v[1]),
    .out_ready(ready_v[1]), .out_valid(valid_v[1]), .ck_out(ck2), .ck_index(idx1),
    .last(last_v[1]), .busy(busy_v[1]));
  sm4_ck_seq #(.LANES(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .dir(dir_v[2]), .flush(flush_v[2]),
    .out_ready(ready_v[2]), .out_valid(valid_v[2]), .ck_out(ck4), .ck_index(idx2),
    .last(last_v[2]), .busy(busy_v[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, req);
  endtask

  task automatic timeout_fail(input string name);
    n_chk++;
    $display("FAIL %s: timed out, got no completion expected completion", name);
  endtask

  function automatic exp_t act_of(input int g);
    exp_t a;
    a = '0;
    case (g)
      0:       begin a.ck = {96'b0, ck1}; a.idx = idx0; a.last = last_v[0]; end
      1:       begin a.ck = {64'b0, ck2}; a.idx = idx1; a.last = last_v[1]; end
      default: begin a.ck = ck4;          a.idx = idx2; a.last = last_v[2]; end
    endcase
    return a;
  endfunction

  function automatic int qsize(input int g);
    case (g)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic push_exp(input int g, input exp_t e);
    case (g)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic pop_exp(input int g, output exp_t e, output bit ok);
    ok = (qsize(g) != 0);
    e  = '0;
    if (ok) begin
      case (g)
        0:       e = q0.pop_front();
        1:       e = q1.pop_front();
        default: e = q2.pop_front();
      endcase
    end
  endtask

  // Expected beats from the hand-written CK table.
  task automatic push_seq(input int g, input bit d, input int nbeats);
    int   lanes;
    int   idx;
    exp_t e;
    lanes = 1 << g;
    for (int b = 0; b < nbeats; b++) begin
      idx    = d ? (31 - b * lanes) : (b * lanes);
      e      = '0;
      e.idx  = 5'(idx);
      e.last = (b == 32 / lanes - 1);
      for (int k = 0; k < lanes; k++) e.ck[32*k +: 32] = ck_tab[d ? idx - k : idx + k];
      push_exp(g, e);
    end
  endtask

  // Monitor: pops on every accepted beat, checks hold under stall and idle after last.
  exp_t prev_act [3];
  bit   prev_stall [3];
  bit   exp_idle [3];

  always @(negedge clk) begin
    exp_t a, e;
    bit   ok;
    if (!rst_n) begin
      for (int g = 0; g < 3; g++) begin prev_stall[g] = 0; exp_idle[g] = 0; end
    end else begin
      for (int g = 0; g < 3; g++) begin
        a = act_of(g);
        if (exp_idle[g]) begin
          check("idle_after_last", 160'({valid_v[g], busy_v[g]}), 160'(0));
          exp_idle[g] = 0;
        end
        if (prev_stall[g])
          check("stall_hold", 160'({valid_v[g], a}), 160'({1'b1, prev_act[g]}));
        if (valid_v[g] && ready_v[g] && !flush_v[g]) begin
          pop_exp(g, e, ok);
          if (!ok) begin
            n_chk++;
            $display("FAIL beat_unexpected lane_cfg=%0d: got idx %0d expected no beat", g, a.idx);
          end else begin
            check("beat", 160'(a), 160'(e));
            if (e.last) exp_idle[g] = 1;
          end
        end
        prev_stall[g] = valid_v[g] && !ready_v[g] && !flush_v[g];
        prev_act[g]   = a;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset();
    check("rst_ctrl", 160'({valid_v, last_v, busy_v}), 160'(0));
    check("rst_idx", 160'({idx0, idx1, idx2}), 160'(0));
    check("rst_ck", 160'({ck1, ck2}), 160'(0));
    check("rst_ck4", 160'(ck4), 160'(0));
  endtask

  // Full sequence on instance g; start pulsed again mid-run must be ignored.
  task automatic run_seq(input int g, input bit d, input bit bp);
    bit done;
    push_seq(g, d, 32 / (1 << g));
    start_v[g] = 1'b1;
    dir_v[g]   = d;
    ready_v[g] = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    cyc();
    start_v[g] = 1'b0;
    dir_v[g]   = ~d;
    done = 0;
    for (int c = 0; c < 400 && !done; c++) begin
      if (bp) ready_v[g] = 1'($urandom_range(0, 1));
      start_v[g] = (c == 3);
      cyc();
      if (qsize(g) == 0 && !busy_v[g]) done = 1;
    end
    start_v[g] = 1'b0;
    ready_v[g] = 1'b0;
    if (!done) timeout_fail("run_seq");
  endtask

  task automatic wait_idx0(input int val);
    bit hit;
    hit = 0;
    for (int c = 0; c < 100 && !hit; c++) begin
      if (valid_v[0] && idx0 == 5'(val)) hit = 1;
      else cyc();
    end
    if (!hit) timeout_fail("wait_idx0");
  endtask

  task automatic flush_test(input bit restart);
    push_seq(0, 1'b0, 5);
    start_v[0] = 1'b1;
    dir_v[0]   = 1'b0;
    ready_v[0] = 1'b1;
    cyc();
    start_v[0] = 1'b0;
    wait_idx0(5);
    flush_v[0] = 1'b1;
    start_v[0] = !restart;
    cyc();
    flush_v[0] = 1'b0;
    start_v[0] = 1'b0;
    check("flush_ctrl", 160'({valid_v[0], last_v[0], busy_v[0]}), 160'(0));
    check("flush_hold", 160'({idx0, ck1}), 160'({5'd5, ck_tab[5]}));
    if (restart) begin
      run_seq(0, 1'b0, 1'b0);
    end else begin
      cyc();
      check("flush_start_ignored", 160'({valid_v[0], busy_v[0]}), 160'(0));
      ready_v[0] = 1'b0;
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    start_v = '0;
    dir_v   = '0;
    flush_v = '0;
    ready_v = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset();
    rst_n = 1'b1;
    cyc();

    run_seq(0, 1'b0, 1'b0);
    run_seq(0, 1'b1, 1'b0);
    run_seq(1, 1'b0, 1'b0);
    run_seq(1, 1'b1, 1'b0);
    run_seq(2, 1'b0, 1'b1);
    run_seq(2, 1'b1, 1'b1);
    run_seq(2, 1'b0, 1'b1);

    flush_test(1'b0);
    flush_test(1'b1);

    // Asynchronous reset in the middle of a sequence.
    push_seq(0, 1'b0, 32);
    start_v[0] = 1'b1;
    dir_v[0]   = 1'b0;
    ready_v[0] = 1'b1;
    cyc();
    start_v[0] = 1'b0;
    wait_idx0(10);
    rst_n = 1'b0;
    q0.delete();
    #1;
    check_reset();
    ready_v[0] = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
    run_seq(0, 1'b0, 1'b0);

    repeat (3) cyc();
    check("sb_drained", 160'(q0.size() + q1.size() + q2.size()), 160'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
